// File: rtl/bridge_arbiter.sv
// bridge_arbiter: shares one bridge target between NUM_REQ
// single-clock requesters, round-robin, one transaction at a time.
module bridge_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int RD_LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_wr,
  input  logic [NUM_REQ-1:0]       req_rd,
  input  logic [NUM_REQ-1:0][31:0] req_addr,
  input  logic [NUM_REQ-1:0][31:0] req_wr_data,
  output logic [NUM_REQ-1:0]       req_busy,
  output logic [NUM_REQ-1:0][31:0] req_rd_data,
  output logic [NUM_REQ-1:0]       req_rd_valid,
  output logic [NUM_REQ-1:0]       req_overrun,
  output logic                     out_wr,
  output logic                     out_rd,
  output logic [31:0]              out_addr,
  output logic [31:0]              out_wr_data,
  input  logic [31:0]              out_rd_data
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RD_WAIT
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        is_wr;
  } slot_t;

  state_t             state;
  slot_t              slot_q [NUM_REQ];
  logic [GW-1:0]      grant;
  logic [GW-1:0]      last_grant;
  logic [GW-1:0]      win;
  logic [CW-1:0]      cnt;
  logic               any;
  logic               done;
  logic [NUM_REQ-1:0] free;

  // the granted slot frees on the cycle its transaction completes
  always_comb begin
    done = ((state == ISSUE) && out_wr) ||
           ((state == RD_WAIT) && (cnt == CW'(1)));
    free = '0;
    if (done) free[grant] = 1'b1;
  end

  // first pending slot after last_grant, wrapping around
  always_comb begin
    int j;
    j   = 0;
    win = '0;
    any = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = int'(last_grant) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any && req_busy[GW'(j)]) begin
        any = 1'b1;
        win = GW'(j);
      end
    end
  end

  // capture strobes into empty slots, flag drops as overrun
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_busy    <= '0;
      req_overrun <= '0;
      for (int i = 0; i < NUM_REQ; i++) slot_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_busy[i]) begin
          if (free[i]) req_busy[i] <= 1'b0;
          if (req_wr[i] || req_rd[i]) req_overrun[i] <= 1'b1;
        end else if (req_wr[i] || req_rd[i]) begin
          req_busy[i] <= 1'b1;
          slot_q[i]   <= {req_addr[i], req_wr_data[i], req_wr[i]};
          if (req_wr[i] && req_rd[i]) req_overrun[i] <= 1'b1;
        end
      end
    end
  end

  // grant, issue one downstream strobe, collect read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      grant        <= '0;
      last_grant   <= GW'(NUM_REQ - 1);
      cnt          <= '0;
      out_wr       <= 1'b0;
      out_rd       <= 1'b0;
      out_addr     <= '0;
      out_wr_data  <= '0;
      req_rd_data  <= '0;
      req_rd_valid <= '0;
    end else begin
      out_wr       <= 1'b0;
      out_rd       <= 1'b0;
      req_rd_valid <= '0;
      unique case (1'b1)
        (state == IDLE): begin
          if (any) begin
            grant       <= win;
            last_grant  <= win;
            out_addr    <= slot_q[win].addr;
            out_wr_data <= slot_q[win].data;
            out_wr      <= slot_q[win].is_wr;
            out_rd      <= !slot_q[win].is_wr;
            state       <= ISSUE;
          end
        end
        (state == ISSUE): begin
          if (out_wr) begin
            state <= IDLE;
          end else begin
            cnt   <= CW'(RD_LATENCY);
            state <= RD_WAIT;
          end
        end
        (state == RD_WAIT): begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            req_rd_data[grant]  <= out_rd_data;
            req_rd_valid[grant] <= 1'b1;
            state               <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
